// File: rtl/fft_stim_pkg.sv
// Shared types for the FFT stimulus player: playback FSM states and config field width.
package fft_stim_pkg;

  localparam int CFG_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP
  } state_t;

endpackage

// File: rtl/fft_stim_player_if.sv
// Control, sample-load, playback and FFT-monitor signals of the stimulus player.
interface fft_stim_player_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 1024
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                         wr_en;
  logic [ADDR_W-1:0]            wr_addr;
  logic [DATA_WIDTH-1:0]        wr_re;
  logic [DATA_WIDTH-1:0]        wr_im;
  logic                         start;
  logic                         stop;
  logic [ADDR_W:0]              frame_len;
  logic [fft_stim_pkg::CFG_W-1:0] gap_len;
  logic [fft_stim_pkg::CFG_W-1:0] repeat_cnt;
  logic                         enable_out;
  logic [DATA_WIDTH-1:0]        out_re;
  logic [DATA_WIDTH-1:0]        out_im;
  logic                         frame_start;
  logic                         frame_done;
  logic                         busy;
  logic                         mon_valid;
  logic [ADDR_W-1:0]            bin_idx;
  logic [fft_stim_pkg::CFG_W-1:0] out_frame_cnt;

  modport master (
    output wr_en, wr_addr, wr_re, wr_im, start, stop, frame_len, gap_len, repeat_cnt, mon_valid,
    input  enable_out, out_re, out_im, frame_start, frame_done, busy, bin_idx, out_frame_cnt
  );

  modport slave (
    input  wr_en, wr_addr, wr_re, wr_im, start, stop, frame_len, gap_len, repeat_cnt, mon_valid,
    output enable_out, out_re, out_im, frame_start, frame_done, busy, bin_idx, out_frame_cnt
  );

endinterface

// File: rtl/fft_sample_ram.sv
// Simple dual-port sample memory, one write port and one registered read port.
// Read latency 1 cycle; a same-address read/write returns the old word; never stalls.
module fft_sample_ram #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 1024,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_dat,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_dat
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
    if (rd_en) rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/fft_stim_player.sv
// Replays frames from sample RAM toward an FFT and counts the FFT's output bins/frames.
// Start to first sample: 2 cycles; no backpressure, one sample per cycle while playing.
module fft_stim_player
  import fft_stim_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 1024
) (
  input logic              clk,
  input logic              rst,
  fft_stim_player_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LEN_W  = ADDR_W + 1;

  state_t                  state;
  logic [ADDR_W-1:0]       rd_addr;
  logic [LEN_W-1:0]        cfg_len;
  logic [CFG_W-1:0]        cfg_gap;
  logic [CFG_W-1:0]        cfg_rep;
  logic [CFG_W-1:0]        frames_played;
  logic [CFG_W-1:0]        gap_cnt;
  logic                    stop_pend;
  logic                    s1_vld;
  logic                    s1_first;
  logic                    s1_last;
  logic [ADDR_W-1:0]       bin_cnt;
  logic [2*DATA_WIDTH-1:0] rd_dat;

  logic                    issue;
  logic                    issue_first;
  logic                    issue_last;
  logic                    last_frame;
  logic                    start_ok;
  logic                    bin_wrap;
  logic [CFG_W-1:0]        frames_next;

  assign issue       = (state == PLAY);
  assign issue_first = (rd_addr == '0);
  assign issue_last  = ({1'b0, rd_addr} == cfg_len - LEN_W'(1));
  assign frames_next = frames_played + CFG_W'(1);
  assign last_frame  = stop_pend || bus.stop || (cfg_rep != '0 && frames_next == cfg_rep);
  assign start_ok    = bus.start && bus.frame_len != '0 && bus.frame_len <= LEN_W'(DEPTH);
  assign bin_wrap    = ({1'b0, bin_cnt} == cfg_len - LEN_W'(1));

  assign bus.busy    = (state != IDLE);
  assign bus.bin_idx = bus.mon_valid ? bin_cnt : '0;

  fft_sample_ram #(
    .WIDTH (2 * DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_dat  ({bus.wr_re, bus.wr_im}),
    .rd_en   (issue),
    .rd_addr (rd_addr),
    .rd_dat  (rd_dat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rd_addr       <= '0;
      cfg_len       <= '0;
      cfg_gap       <= '0;
      cfg_rep       <= '0;
      frames_played <= '0;
      gap_cnt       <= '0;
      stop_pend     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            state         <= PLAY;
            cfg_len       <= bus.frame_len;
            cfg_gap       <= bus.gap_len;
            cfg_rep       <= bus.repeat_cnt;
            rd_addr       <= '0;
            frames_played <= '0;
            stop_pend     <= 1'b0;
          end
        end
        PLAY: begin
          // A stop only takes effect at the frame boundary, so remember it until then.
          if (bus.stop) stop_pend <= 1'b1;
          if (issue_last) begin
            rd_addr       <= '0;
            frames_played <= frames_next;
            if (last_frame) begin
              state <= IDLE;
            end else if (cfg_gap != '0) begin
              state   <= GAP;
              gap_cnt <= cfg_gap - CFG_W'(1);
            end
          end else begin
            rd_addr <= rd_addr + ADDR_W'(1);
          end
        end
        GAP: begin
          if (bus.stop)             state   <= IDLE;
          else if (gap_cnt == '0)   state   <= PLAY;
          else                      gap_cnt <= gap_cnt - CFG_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-stage pipeline: RAM read register, then output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld          <= 1'b0;
      s1_first        <= 1'b0;
      s1_last         <= 1'b0;
      bus.enable_out  <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.frame_done  <= 1'b0;
      bus.out_re      <= '0;
      bus.out_im      <= '0;
    end else begin
      s1_vld          <= issue;
      s1_first        <= issue && issue_first;
      s1_last         <= issue && issue_last;
      bus.enable_out  <= s1_vld;
      bus.frame_start <= s1_first;
      bus.frame_done  <= s1_last;
      if (s1_vld) {bus.out_re, bus.out_im} <= rd_dat;
    end
  end

  // A gap in mon_valid restarts bin numbering at 0 for the next burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_cnt           <= '0;
      bus.out_frame_cnt <= '0;
    end else if (!bus.mon_valid) begin
      bin_cnt <= '0;
    end else if (bin_wrap) begin
      bin_cnt           <= '0;
      bus.out_frame_cnt <= bus.out_frame_cnt + CFG_W'(1);
    end else begin
      bin_cnt <= bin_cnt + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_fft_stim_player.sv
// Bench for fft_stim_player: directed scenarios plus randomized playback against a frame-schedule model.
module tb_fft_stim_player;

  localparam int DW    = 8;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int LW    = AW + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_stim_player_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  fft_stim_player #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_on = 1'b0;

  // Model: one playback record (first output cycle, length, gap, frame limit; 0 = endless).
  logic [DW-1:0] m_re [DEPTH];
  logic [DW-1:0] m_im [DEPTH];
  bit   act = 1'b0;
  int   s_out = 0, p_len = 1, p_gap = 0, nfr = 0;
  int   lat_len = 0, m_bin = 0;
  logic [15:0] m_ofc = '0;
  bit   x_en = 0, x_fs = 0, x_fd = 0, n_en = 0, n_fs = 0, n_fd = 0;
  logic [DW-1:0] x_re = '0, x_im = '0, n_re = '0, n_im = '0;

  // Observations of the DUT stream, cleared per scenario.
  int en_cnt = 0, fs_cnt = 0, fd_cnt = 0, first_cyc = 0, hist_n = 0;
  int first_re = 0, last_re = 0, last_im = 0;
  logic [63:0] hist = '0;

  function automatic int last_out();
    return s_out + (nfr - 1) * (p_len + p_gap) + p_len - 1;
  endfunction

  function automatic bit busy_at(int c);
    return act && (c + 2 >= s_out) && (nfr == 0 || c + 2 <= last_out());
  endfunction

  task automatic chk(string nm, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, got, exp);
    end
  endtask

  always @(posedge clk) begin
    bit bp;
    int off, f, k;
    cyc = cyc + 1;
    x_en = n_en; x_fs = n_fs; x_fd = n_fd; x_re = n_re; x_im = n_im;
    if (rst) begin
      act = 0; lat_len = 0; m_bin = 0; m_ofc = '0;
      x_en = 0; x_fs = 0; x_fd = 0; x_re = '0; x_im = '0;
    end else begin
      bp = busy_at(cyc - 1);
      if (bus.mon_valid) begin
        if (m_bin == lat_len - 1) begin m_bin = 0; m_ofc = m_ofc + 16'd1; end
        else m_bin = m_bin + 1;
      end else begin
        m_bin = 0;
      end
      if (bus.stop && bp) begin
        k = (cyc + 1 - s_out) / (p_len + p_gap) + 1;
        if (nfr == 0 || k < nfr) nfr = k;
      end
      if (bus.start && !bp && bus.frame_len >= 1 && bus.frame_len <= DEPTH) begin
        act = 1; s_out = cyc + 2; p_len = int'(bus.frame_len);
        p_gap = int'(bus.gap_len); nfr = int'(bus.repeat_cnt); lat_len = p_len;
      end
    end
    n_en = 0; n_fs = 0; n_fd = 0; n_re = x_re; n_im = x_im;
    if (act && cyc + 1 >= s_out) begin
      off = cyc + 1 - s_out;
      f   = off / (p_len + p_gap);
      k   = off % (p_len + p_gap);
      if (k < p_len && (nfr == 0 || f < nfr)) begin
        n_en = 1; n_fs = (k == 0); n_fd = (k == p_len - 1); n_re = m_re[k]; n_im = m_im[k];
      end
    end
    if (bus.wr_en) begin
      m_re[bus.wr_addr] = bus.wr_re;
      m_im[bus.wr_addr] = bus.wr_im;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("enable_out", int'(bus.enable_out), int'(x_en));
      chk("frame_start", int'(bus.frame_start), int'(x_fs));
      chk("frame_done", int'(bus.frame_done), int'(x_fd));
      chk("busy", int'(bus.busy), int'(busy_at(cyc)));
      chk("bin_idx", int'(bus.bin_idx), bus.mon_valid ? m_bin : 0);
      chk("out_frame_cnt", int'(bus.out_frame_cnt), int'(m_ofc));
      if (x_en) begin
        chk("out_re", int'(bus.out_re), int'(x_re));
        chk("out_im", int'(bus.out_im), int'(x_im));
      end
    end
    if (bus.enable_out) begin
      if (en_cnt == 0) begin first_cyc = cyc; first_re = int'(bus.out_re); end
      en_cnt++;
      last_re = int'(bus.out_re);
      last_im = int'(bus.out_im);
    end
    fs_cnt += int'(bus.frame_start);
    fd_cnt += int'(bus.frame_done);
    if (hist_n < 30 && (hist_n > 0 || bus.enable_out)) begin
      hist = {hist[62:0], bus.enable_out};
      hist_n++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_track();
    en_cnt = 0; fs_cnt = 0; fd_cnt = 0; hist_n = 0; hist = '0;
    first_cyc = 0; first_re = -1; last_re = -1; last_im = -1;
  endtask

  task automatic do_start(int len, int gap, int rep);
    bus.start      = 1'b1;
    bus.frame_len  = LW'(len);
    bus.gap_len    = 16'(gap);
    bus.repeat_cnt = 16'(rep);
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  task automatic wait_idle(string nm);
    int n = 0;
    while (bus.busy && n < 2000) begin tick(); n++; end
    chk({nm, " busy drops"}, int'(bus.busy), 0);
    repeat (4) tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, required completion within time limit");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int st, n;
    rst = 1'b1;
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_re = '0; bus.wr_im = '0;
    bus.start = 0; bus.stop = 0; bus.frame_len = '0; bus.gap_len = '0;
    bus.repeat_cnt = '0; bus.mon_valid = 0;
    repeat (3) tick();
    chk_on = 1'b1;
    @(negedge clk);
    chk("reset enable_out", int'(bus.enable_out), 0);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset frame_start", int'(bus.frame_start), 0);
    chk("reset frame_done", int'(bus.frame_done), 0);
    chk("reset out_re", int'(bus.out_re), 0);
    chk("reset out_im", int'(bus.out_im), 0);
    chk("reset bin_idx", int'(bus.bin_idx), 0);
    chk("reset out_frame_cnt", int'(bus.out_frame_cnt), 0);
    tick();
    rst = 1'b0;

    for (int k = 0; k < DEPTH; k++) begin
      bus.wr_en = 1; bus.wr_addr = AW'(k); bus.wr_re = DW'(k); bus.wr_im = DW'(-k);
      tick();
    end
    bus.wr_en = 0;
    repeat (2) tick();

    // Single 64-sample frame.
    clr_track();
    do_start(64, 0, 1);
    st = cyc;
    wait_idle("single frame");
    chk("single en cycles", en_cnt, 64);
    chk("single first latency", first_cyc - st, 2);
    chk("single frame_start count", fs_cnt, 1);
    chk("single frame_done count", fd_cnt, 1);
    chk("single first out_re", first_re, 0);
    chk("single last out_re", last_re, 63);

    // Three 8-sample frames separated by 3-cycle gaps.
    clr_track();
    do_start(8, 3, 3);
    wait_idle("gapped frames");
    chk("gapped pattern", int'(hist[29:0]), int'(30'b11111111_000_11111111_000_11111111));
    chk("gapped en cycles", en_cnt, 24);
    chk("gapped frame_done count", fd_cnt, 3);
    chk("gapped busy after", int'(bus.busy), 0);

    // Continuous play, graceful stop during frame 2.
    clr_track();
    do_start(16, 2, 0);
    n = 0;
    while (!(fs_cnt == 2 && last_re == 5) && n < 300) begin tick(); n++; end
    chk("stop reached frame 2 sample 5", int'(fs_cnt == 2 && last_re == 5), 1);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    wait_idle("graceful stop");
    chk("stop en cycles", en_cnt, 32);
    chk("stop frame_start count", fs_cnt, 2);
    chk("stop frame_done count", fd_cnt, 2);

    // Out-of-range frame lengths are rejected.
    clr_track();
    do_start(0, 0, 1);
    repeat (5) tick();
    chk("len0 busy", int'(bus.busy), 0);
    do_start(DEPTH + 1, 0, 1);
    repeat (5) tick();
    chk("len overflow busy", int'(bus.busy), 0);
    chk("bad len en cycles", en_cnt, 0);

    // Monitor: 2 frames of 32 bins.
    do_start(32, 0, 1);
    wait_idle("monitor setup");
    bus.mon_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      #2;
      chk("monitor bin_idx", int'(bus.bin_idx), i % 32);
      tick();
    end
    bus.mon_valid = 1'b0;
    #2;
    chk("monitor bin_idx idle", int'(bus.bin_idx), 0);
    tick();
    chk("monitor out_frame_cnt", int'(bus.out_frame_cnt), 2);
    chk("monitor bin_idx after", int'(bus.bin_idx), 0);

    // Reset in mid-frame, then replay.
    clr_track();
    do_start(64, 0, 1);
    n = 0;
    while (last_re != 10 && n < 100) begin tick(); n++; end
    chk("reset point reached", last_re, 10);
    rst = 1'b1;
    tick();
    chk("midreset enable_out", int'(bus.enable_out), 0);
    chk("midreset busy", int'(bus.busy), 0);
    chk("midreset frame_start", int'(bus.frame_start), 0);
    chk("midreset frame_done", int'(bus.frame_done), 0);
    chk("midreset out_re", int'(bus.out_re), 0);
    chk("midreset out_im", int'(bus.out_im), 0);
    chk("midreset out_frame_cnt", int'(bus.out_frame_cnt), 0);
    rst = 1'b0;
    repeat (2) tick();
    clr_track();
    do_start(64, 0, 1);
    wait_idle("replay");
    chk("replay en cycles", en_cnt, 64);
    chk("replay first out_re", first_re, 0);
    chk("replay last out_re", last_re, 63);
    chk("replay last out_im", last_im, 8'hC1);

    // Randomized playback with concurrent writes, monitor traffic, stray starts and stops.
    for (int it = 0; it < 40; it++) begin
      int len, gap, rep;
      len = $urandom_range(1, 40);
      if ($urandom_range(0, 7) == 0) len = ($urandom_range(0, 1) == 1) ? 0 : DEPTH + 1;
      gap = $urandom_range(0, 4);
      rep = $urandom_range(0, 3);
      bus.stop = ($urandom_range(0, 3) == 0);
      do_start(len, gap, rep);
      n = 0;
      while ((busy_at(cyc) || n < 3) && n < 600) begin
        bus.wr_en     = ($urandom_range(0, 3) == 0);
        bus.wr_addr   = AW'($urandom_range(0, 63));
        bus.wr_re     = DW'($urandom);
        bus.wr_im     = DW'($urandom);
        bus.mon_valid = ($urandom_range(0, 3) != 0);
        bus.start     = busy_at(cyc) && ($urandom_range(0, 29) == 0);
        if (bus.start) bus.frame_len = LW'($urandom_range(1, 50));
        bus.stop      = busy_at(cyc) && ($urandom_range(0, 59) == 0 || (rep == 0 && n >= 120));
        tick();
        n++;
      end
      bus.wr_en = 0; bus.mon_valid = 0; bus.start = 0; bus.stop = 0;
      chk("random run ends", int'(n < 600), 1);
      repeat (4) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
